// File: rtl/alu_mult_sequencer.sv
// alu_mult_sequencer: 32x32 low-word multiply computed as a shift-add loop on the shared ALU.
// The ALU does the adds and the one-bit shifts of the multiplicand. This block only sequences
// the ALU and holds the loop registers.
module alu_mult_sequencer #(
  parameter int unsigned MAX_ITER = 32,
  parameter logic [3:0]  ALU_ADD  = 4'b0010,
  parameter logic [3:0]  ALU_SLL  = 4'b1110,
  parameter logic [3:0]  ALU_AND  = 4'b0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] product,
  output logic [31:0] alu_rs,
  output logic [31:0] alu_rt,
  output logic [4:0]  alu_shamt,
  output logic [3:0]  alu_ctrl,
  input  logic [31:0] alu_result
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ADD   = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [5:0] CNT_LAST = 6'(MAX_ITER - 1);

  logic [1:0]  state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] m_q, m_d;
  logic [31:0] q_q, q_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] product_q, product_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  // Next-state logic for the shift-add loop and the registered handshake outputs.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    m_d       = m_q;
    q_d       = q_q;
    cnt_d     = cnt_q;
    product_d = product_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_d   = 32'd0;
          m_d     = op_a;
          q_d     = op_b;
          cnt_d   = 6'd0;
          state_d = (op_b == 32'd0) ? ST_DONE : ST_ADD;
        end
      end
      ST_ADD: begin
        // Accumulate the current multiplicand only when the multiplier LSB is set.
        if (q_q[0]) begin
          acc_d = alu_result;
        end
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        m_d   = alu_result;
        q_d   = q_q >> 1;
        cnt_d = cnt_q + 6'd1;
        // Stop early once no multiplier bits remain.
        if ((q_q[31:1] == 31'd0) || (cnt_q == CNT_LAST)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_ADD;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // acc_d covers the op_b==0 path, where acc is cleared on the same edge.
    if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
      product_d = acc_d;
    end

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      acc_q     <= 32'd0;
      m_q       <= 32'd0;
      q_q       <= 32'd0;
      cnt_q     <= 6'd0;
      product_q <= 32'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      m_q       <= m_d;
      q_q       <= q_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // ALU operand/opcode decode from state only, so alu_result never feeds back combinationally.
  always_comb begin
    alu_ctrl  = ALU_AND;
    alu_rs    = 32'd0;
    alu_rt    = 32'd0;
    alu_shamt = 5'd0;
    case (state_q)
      ST_ADD: begin
        alu_ctrl = ALU_ADD;
        alu_rs   = acc_q;
        alu_rt   = m_q;
      end
      ST_SHIFT: begin
        alu_ctrl  = ALU_SLL;
        alu_rt    = m_q;
        alu_shamt = 5'd1;
      end
      default: begin
      end
    endcase
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_alu_mult_sequencer.sv
// Directed bench for alu_mult_sequencer with a small behavioural ALU attached.
module tb_alu_mult_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic [31:0] product;
  logic [31:0] alu_rs;
  logic [31:0] alu_rt;
  logic [4:0]  alu_shamt;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_result;

  int checks = 0;
  int errors = 0;

  alu_mult_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .op_a       (op_a),
    .op_b       (op_b),
    .busy       (busy),
    .done       (done),
    .product    (product),
    .alu_rs     (alu_rs),
    .alu_rt     (alu_rt),
    .alu_shamt  (alu_shamt),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result)
  );

  // Shared single-cycle ALU, reduced to the operations used here.
  always_comb begin
    case (alu_ctrl)
      4'b0010: alu_result = alu_rs + alu_rt;
      4'b1110: alu_result = alu_rt << alu_shamt;
      4'b0000: alu_result = alu_rs & alu_rt;
      default: alu_result = 32'hDEAD_BEEF;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_alu_idle(input string tag);
    chk({tag, ".ctrl"}, 32'(alu_ctrl), 32'h0);
    chk({tag, ".rs"}, alu_rs, 32'h0);
    chk({tag, ".rt"}, alu_rt, 32'h0);
    chk({tag, ".shamt"}, 32'(alu_shamt), 32'h0);
  endtask

  // Issue one multiply and follow it through to the idle cycle after done.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_p, input int exp_edges);
    int n;
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    op_a  = ~a;
    op_b  = ~b;
    chk({tag, ".busy_accept"}, 32'(busy), 32'h1);
    if (b != 32'd0) begin
      chk({tag, ".add_ctrl"}, 32'(alu_ctrl), 32'h2);
      chk({tag, ".add_rs"}, alu_rs, 32'h0);
      chk({tag, ".add_rt"}, alu_rt, a);
      chk({tag, ".add_shamt"}, 32'(alu_shamt), 32'h0);
    end
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      tick();
      n++;
      if (n == 1 && b != 32'd0) begin
        chk({tag, ".sll_ctrl"}, 32'(alu_ctrl), 32'hE);
        chk({tag, ".sll_rt"}, alu_rt, a);
        chk({tag, ".sll_shamt"}, 32'(alu_shamt), 32'h1);
        chk({tag, ".sll_rs"}, alu_rs, 32'h0);
      end
    end
    chk({tag, ".edges"}, 32'(n), 32'(exp_edges));
    chk({tag, ".done"}, 32'(done), 32'h1);
    chk({tag, ".product"}, product, exp_p);
    chk({tag, ".busy_done"}, 32'(busy), 32'h1);
    chk({tag, ".done_ctrl"}, 32'(alu_ctrl), 32'h0);
    tick();
    chk({tag, ".done_pulse"}, 32'(done), 32'h0);
    chk({tag, ".busy_after"}, 32'(busy), 32'h0);
    chk({tag, ".product_hold"}, product, exp_p);
    chk_alu_idle({tag, ".idle"});
  endtask

  initial begin
    int n;
    reset = 1'b1;
    start = 1'b0;
    op_a  = 32'd0;
    op_b  = 32'd0;
    tick();
    tick();
    chk("rst.busy", 32'(busy), 32'h0);
    chk("rst.done", 32'(done), 32'h0);
    chk("rst.product", product, 32'h0);
    chk_alu_idle("rst.alu");
    reset = 1'b0;
    tick();

    run_op("mul6x7", 32'd6, 32'd7, 32'd42, 6);
    run_op("neg3x5", 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 6);
    run_op("allones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 64);
    run_op("ovf", 32'h0001_0000, 32'h0001_0000, 32'h0, 34);
    run_op("zero_b", 32'd123, 32'd0, 32'h0, 0);

    // start while busy must be ignored; also follow acc through the second ADD.
    op_a  = 32'd6;
    op_b  = 32'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("ign.sll_rt", alu_rt, 32'd6);
    tick();
    chk("ign.add2_rs", alu_rs, 32'd6);
    chk("ign.add2_rt", alu_rt, 32'd12);
    op_a  = 32'd9;
    op_b  = 32'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 3;
    while (done !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk("ign.edges", 32'(n), 32'd6);
    chk("ign.product", product, 32'd42);
    tick();
    tick();
    chk("ign.busy_after", 32'(busy), 32'h0);
    chk("ign.product_hold", product, 32'd42);

    // Reset in the middle of 6*7 aborts without a done pulse.
    op_a  = 32'd6;
    op_b  = 32'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    chk("abort.busy_before", 32'(busy), 32'h1);
    reset = 1'b1;
    #1;
    chk("abort.busy", 32'(busy), 32'h0);
    chk("abort.done", 32'(done), 32'h0);
    chk("abort.product", product, 32'h0);
    chk_alu_idle("abort.alu");
    tick();
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done === 1'b1) n++;
    end
    chk("abort.no_done", 32'(n), 32'h0);
    chk("abort.product_after", product, 32'h0);

    run_op("mul2x3", 32'd2, 32'd3, 32'd6, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
